// File: rtl/fixed_activation_lut_arbiter.sv
// Shared activation LUT: streaming table load, round-robin lookup arbitration across NUM_REQ lanes.
// Latency: one cycle from the req handshake to rsp_valid, with data mem[req_data slice].
// Backpressure: a lane is granted only when its response slot is free or draining this cycle.
module fixed_activation_lut_arbiter #(
  parameter int DATA_IN_0_PRECISION_0  = 8,
  parameter int DATA_OUT_0_PRECISION_0 = 8,
  parameter int NUM_REQ                = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      cfg_load_start,
  input  logic [DATA_OUT_0_PRECISION_0-1:0]         cfg_data,
  input  logic                                      cfg_valid,
  output logic                                      cfg_ready,
  output logic                                      lut_loaded,
  input  logic [NUM_REQ*DATA_IN_0_PRECISION_0-1:0]  req_data,
  input  logic [NUM_REQ-1:0]                        req_valid,
  output logic [NUM_REQ-1:0]                        req_ready,
  output logic [NUM_REQ*DATA_OUT_0_PRECISION_0-1:0] rsp_data,
  output logic [NUM_REQ-1:0]                        rsp_valid,
  input  logic [NUM_REQ-1:0]                        rsp_ready
);

  localparam int DIW       = DATA_IN_0_PRECISION_0;
  localparam int DOW       = DATA_OUT_0_PRECISION_0;
  localparam int LUT_DEPTH = 2 ** DIW;
  localparam int PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t             state, state_nxt;
  logic [DIW-1:0]     wr_cnt, wr_cnt_nxt;
  logic               wr_en;
  logic [PW-1:0]      rr_ptr;
  logic [DOW-1:0]     mem [LUT_DEPTH];
  logic [DOW-1:0]     rsp_q [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_vld;
  logic [PW-1:0]      gnt_idx;
  logic [DIW-1:0]     lut_idx;
  int                 idx;

  // Load FSM: next state, write strobe and status flags
  always_comb begin
    state_nxt  = state;
    wr_cnt_nxt = wr_cnt;
    wr_en      = 1'b0;
    cfg_ready  = 1'b0;
    lut_loaded = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_load_start) begin
          state_nxt  = LOAD;
          wr_cnt_nxt = '0;
        end
      end
      LOAD: begin
        cfg_ready = 1'b1;
        // A restart pulse wins over a word arriving in the same cycle.
        if (cfg_load_start) begin
          wr_cnt_nxt = '0;
        end else if (cfg_valid) begin
          wr_en      = 1'b1;
          wr_cnt_nxt = wr_cnt + 1'b1;
          if (&wr_cnt) state_nxt = RUN;
        end
      end
      RUN: begin
        lut_loaded = 1'b1;
        if (cfg_load_start) begin
          state_nxt  = LOAD;
          wr_cnt_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Round-robin grant: first eligible lane after the last granted one
  always_comb begin
    eligible = '0;
    gnt      = '0;
    gnt_vld  = 1'b0;
    gnt_idx  = rr_ptr;
    idx      = 0;
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = req_valid[i] & (~rsp_valid[i] | rsp_ready[i]);
    if (state == RUN && !cfg_load_start) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (int'(rr_ptr) + k) % NUM_REQ;
        if (!gnt_vld && eligible[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = PW'(idx);
        end
      end
    end
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
    req_ready = gnt;
    lut_idx   = req_data[int'(gnt_idx)*DIW +: DIW];
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      wr_cnt <= '0;
      rr_ptr <= PW'(NUM_REQ - 1);
    end else begin
      state  <= state_nxt;
      wr_cnt <= wr_cnt_nxt;
      if (gnt_vld) rr_ptr <= gnt_idx;
    end
  end

  // Table write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_cnt] <= cfg_data;
  end

  // Per-lane response slots: reload on grant, clear on drain
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      for (int i = 0; i < NUM_REQ; i++) rsp_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i]) begin
          rsp_valid[i] <= 1'b1;
          rsp_q[i]     <= mem[lut_idx];
        end else if (rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
    assign rsp_data[g*DOW +: DOW] = rsp_q[g];
  end

endmodule

// File: tb/tb_fixed_activation_lut_arbiter.sv
// Bench for the shared activation LUT arbiter: reference model plus per-lane response scoreboard.
module tb_fixed_activation_lut_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_load_start;
  logic [7:0]    cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          lut_loaded;
  logic [N*8-1:0] req_data;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*8-1:0] rsp_data;
  logic [N-1:0]  rsp_valid;
  logic [N-1:0]  rsp_ready;

  int checks = 0;
  int errors = 0;

  fixed_activation_lut_arbiter #(
    .DATA_IN_0_PRECISION_0(8), .DATA_OUT_0_PRECISION_0(8), .NUM_REQ(N)
  ) dut (
    .clk(clk), .rst(rst), .cfg_load_start(cfg_load_start), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .lut_loaded(lut_loaded),
    .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: table image, load mode, last-granted lane, expected responses per lane
  logic [7:0] m_mem [256];
  int         m_mode;   // 0 idle, 1 loading, 2 lookups enabled
  int         m_cnt;
  int         m_ptr;
  bit         known = 1'b0;
  logic [7:0] sb_q [N][$];

  // Monitor: compare outputs mid-cycle, then advance the model across the coming edge
  initial begin
    int g;
    int exp_rdy;
    forever begin
      @(negedge clk);
      g = -1;
      if (known) begin
        check("cfg_ready", int'(cfg_ready), int'(m_mode == 1));
        check("lut_loaded", int'(lut_loaded), int'(m_mode == 2));
        if (m_mode == 2 && !cfg_load_start) begin
          for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (g < 0 && req_valid[j] && (sb_q[j].size() == 0 || rsp_ready[j])) g = j;
          end
        end
        exp_rdy = (g >= 0) ? (1 << g) : 0;
        check("req_ready", int'(req_ready), exp_rdy);
        for (int i = 0; i < N; i++) begin
          check($sformatf("rsp_valid%0d", i), int'(rsp_valid[i]), int'(sb_q[i].size() != 0));
          if (sb_q[i].size() != 0)
            check($sformatf("rsp_data%0d", i), int'(rsp_data[i*8 +: 8]), int'(sb_q[i][0]));
        end
      end
      if (rst) begin
        known  = 1'b1;
        m_mode = 0;
        m_cnt  = 0;
        m_ptr  = N - 1;
        for (int i = 0; i < N; i++) sb_q[i].delete();
      end else if (known) begin
        for (int i = 0; i < N; i++)
          if (sb_q[i].size() != 0 && rsp_ready[i]) void'(sb_q[i].pop_front());
        if (g >= 0) begin
          sb_q[g].push_back(m_mem[req_data[g*8 +: 8]]);
          m_ptr = g;
        end
        if (cfg_load_start) begin
          m_mode = 1;
          m_cnt  = 0;
        end else if (m_mode == 1 && cfg_valid) begin
          m_mem[m_cnt] = cfg_data;
          m_cnt++;
          if (m_cnt == 256) begin
            m_mode = 2;
            m_cnt  = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse load start, then stream n words with random gaps; inv selects image ~i instead of i+1
  task automatic stream(input int n, input bit inv);
    int acc = 0;
    int cyc = 0;
    cfg_load_start = 1'b1;
    tick();
    cfg_load_start = 1'b0;
    rsp_ready = '1;
    while (acc < n && cyc < 4000) begin
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_data  = inv ? ~8'(acc) : 8'(acc + 1);
      @(negedge clk);
      if (cfg_valid && cfg_ready) acc++;
      tick();
      cyc++;
    end
    cfg_valid = 1'b0;
    if (acc < n) check("load_timeout", acc, n);
  endtask

  // Single directed lookup on lane 0 with a fixed expected result
  task automatic lookup0(input logic [7:0] index, input int exp, input string name);
    req_valid = 4'b0001;
    req_data  = {24'h0, index};
    rsp_ready = '1;
    @(negedge clk);
    check({name, "_grant"}, int'(req_ready), 1);
    tick();
    req_valid = '0;
    @(negedge clk);
    check({name, "_valid"}, int'(rsp_valid[0]), 1);
    check(name, int'(rsp_data[7:0]), exp);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    cfg_load_start = 1'b0;
    cfg_data = '0;
    cfg_valid = 1'b0;
    req_data = '0;
    req_valid = '0;
    rsp_ready = '1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_rsp_data", int'(rsp_data), 0);

    // No image loaded: requests must be ignored
    req_valid = 4'b1111;
    req_data  = $urandom;
    repeat (20) tick();
    req_valid = '0;

    // First image (i+1), then directed lookups
    stream(256, 1'b0);
    @(negedge clk);
    check("loaded_after_load", int'(lut_loaded), 1);
    tick();
    lookup0(8'h05, 8'h06, "lut_05");
    lookup0(8'hFF, 8'h00, "lut_FF");

    // All lanes busy, all consumers ready: strict rotation
    req_valid = 4'b1111;
    for (int c = 0; c < 40; c++) begin
      req_data = $urandom;
      tick();
    end

    // Lane 1 consumer stalled, others keep rotating
    rsp_ready = 4'b1101;
    for (int c = 0; c < 20; c++) begin
      req_data = $urandom;
      tick();
    end
    rsp_ready = 4'b1111;
    tick();

    // Fully random traffic
    for (int c = 0; c < 300; c++) begin
      req_valid = 4'($urandom);
      rsp_ready = 4'($urandom);
      req_data  = $urandom;
      tick();
    end

    // Reload with lane 2 holding an old-image response
    req_valid = '0;
    rsp_ready = '1;
    repeat (2) tick();
    rsp_ready = 4'b1011;
    req_valid = 4'b0100;
    req_data  = 32'h0005_0000;
    tick();
    req_valid = 4'b1111;
    req_data  = $urandom;
    stream(256, 1'b1);
    req_valid = '0;
    tick();
    lookup0(8'h05, 8'hFA, "lut_new_05");

    // Reset in the middle of a load
    stream(100, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_cfg_ready", int'(cfg_ready), 0);
    check("rst_lut_loaded", int'(lut_loaded), 0);
    cfg_valid = 1'b1;
    cfg_data  = 8'hAA;
    req_valid = 4'b1111;
    repeat (10) tick();
    cfg_valid = 1'b0;
    req_valid = '0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fixed_activation_lut_arbiter.md
Name: fixed_activation_lut_arbiter

Overview:
- Shares one programmable activation lookup table (SiLU, GELU or similar maps) between NUM_REQ independent element streams.
- Loads the table contents from a streaming configuration port, so no file-based initialisation is needed.
- Round-robin arbitrates one lookup per cycle across requesters, with one registered response slot per requester.
- Sits between the unpacked FIFO/roller stage and downstream consumers when several activation lanes share a single LUT memory.

Parameters:
- DATA_IN_0_PRECISION_0, 8, input element width; LUT_DEPTH = 2**DATA_IN_0_PRECISION_0 (localparam).
- DATA_OUT_0_PRECISION_0, 8, LUT entry / output element width.
- NUM_REQ, 4, number of requester streams (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_load_start  in  1  single-cycle pulse: begin (re)load of table.
- cfg_data  in  DATA_OUT_0_PRECISION_0  table word; addresses implicit, 0 up to LUT_DEPTH-1.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  table word accepted when cfg_valid&cfg_ready.
- lut_loaded  out  1  table holds a complete image; lookups enabled.
- req_data  in  NUM_REQ*DATA_IN_0_PRECISION_0  flattened; slice i belongs to requester i.
- req_valid  in  NUM_REQ  per-requester valid.
- req_ready  out  NUM_REQ  per-requester ready (one-hot or zero).
- rsp_data  out  NUM_REQ*DATA_OUT_0_PRECISION_0  flattened responses.
- rsp_valid  out  NUM_REQ  per-requester response valid.
- rsp_ready  in  NUM_REQ  per-requester response ready.

Behaviour:
- Single clock domain; rst is synchronous and active-high.
- Reset values:
  - FSM=IDLE, write counter=0, RR pointer=NUM_REQ-1 (requester 0 has first priority).
  - cfg_ready=0, lut_loaded=0, req_ready=0, rsp_valid=0, rsp_data=0.
  - Table memory contents are not cleared.
- FSM states:
  - IDLE: no valid image. cfg_load_start -> LOAD.
  - LOAD: cfg_ready=1; each accepted word is written to mem[counter] and the counter increments.
    - Accepting word LUT_DEPTH-1 -> RUN on the next cycle, with cfg_ready=0 and lut_loaded=1 from that cycle.
    - cfg_load_start while in LOAD resets the counter to 0 and stays in LOAD. A word accepted in the same cycle is discarded.
  - RUN: lookups enabled. cfg_load_start -> LOAD, counter=0, lut_loaded=0 next cycle.
- lut_loaded is high only in RUN. cfg_valid outside LOAD is ignored.
- Arbitration:
  - Applies only in RUN and only in cycles with no cfg_load_start.
  - Requester i is eligible when req_valid[i] and its slot is free: (!rsp_valid[i] || rsp_ready[i]).
  - The first eligible index searching from pointer+1 modulo NUM_REQ is granted. req_ready is one-hot on the grant, else all zero.
  - req_ready depends combinationally on req_valid and rsp_ready.
  - The pointer updates to the granted index only on a grant; otherwise it holds.
- Lookup:
  - Index = raw unsigned bit pattern of the req_data slice (two's-complement input wraps naturally).
  - Synchronous read, written into the granted slot at the handshake edge.
  - Latency: handshake in cycle N gives rsp_valid[i]=1 with mem[index] in cycle N+1.
- Response slots:
  - rsp_valid[i] clears after the edge where rsp_valid[i]&rsp_ready[i] holds, unless a new grant to i occurs in the same cycle; then the slot reloads and stays valid.
  - rsp_data[i] is stable while valid and not ready.
- Reload while responses are pending: existing rsp slots keep their already-read values and still drain. No new grants until RUN is re-entered.
- Throughput: at most one lookup per cycle in total. Back-to-back grants to the same requester are allowed only when NUM_REQ=1 or no other requester is eligible.
- Reset mid-load or mid-run: immediately returns to reset values; a full reload is required.

Test Plan:
- Reset; hold req_valid=4'b1111 for 20 cycles without loading -> req_ready=0, rsp_valid=0 throughout, cfg_ready=0.
- Pulse cfg_load_start, stream 256 words with value (i+1)&8'hFF, cfg_valid toggling randomly -> cfg_ready falls and lut_loaded rises the cycle after the 256th accept. Then req0 0x05 -> rsp0 0x06 one cycle after the handshake; 0xFF -> 0x00.
- All 4 requesters valid continuously, rsp_ready=4'b1111 -> grants 0,1,2,3,0,... one per cycle; each rsp_valid pulses every 4th cycle with the correct values.
- rsp_ready[1]=0 with req1 valid -> one lookup granted; rsp1 is held stable and req_ready[1]=0 until rsp_ready[1]=1. Requesters 0,2,3 continue round-robin without gaps.
- Reload in RUN with rsp2 pending (old value 0x06), new image ~i -> no grants from the load_start cycle onward; rsp2 still delivers 0x06. After the reload, 0x05 -> 0xFA.
- rst after 100 words loaded -> next cycle cfg_ready=0, lut_loaded=0, FSM IDLE; further cfg_valid is ignored until cfg_load_start.
